// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the fixed-ratio clock divider.
package clk_div_pkg;

    localparam int unsigned IN_FREQ_HZ_DEF  = 50_000_000;
    localparam int unsigned OUT_FREQ_HZ_DEF = 100;

    // Input cycles per output half-period; 0 flags an unusable output frequency.
    function automatic int unsigned half_cnt(input int unsigned in_hz, input int unsigned out_hz);
        if (out_hz == 0) begin
            return 0;
        end
        return in_hz / (2 * out_hz);
    endfunction

    // Counter width for a modulo-half counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned half);
        if (half > 1) begin
            return 32'($clog2(half));
        end
        return 1;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-HALF_CNT counter with a terminal-count strobe, synchronous active-low reset.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int unsigned HALF_CNT = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tc_c
);

    localparam int unsigned      CNT_W    = cnt_width(HALF_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CNT - 1);

    logic [CNT_W-1:0] cnt;

    // Terminal count: the edge that wraps the counter is the edge that toggles the output.
    assign tc_c = (cnt == CNT_LAST);

    // Count 0..HALF_CNT-1 and wrap; the counter never passes CNT_LAST.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tc_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_divider_100hz.sv
// 50 MHz -> 100 Hz, 50% duty registered divider.
// Optional macro CLK_DIV_TICK_EN adds tick_100Hz, a one-cycle pulse on each 0->1 output edge.
module clk_divider_100hz
    import clk_div_pkg::*;
#(
    parameter int unsigned IN_FREQ_HZ  = IN_FREQ_HZ_DEF,
    parameter int unsigned OUT_FREQ_HZ = OUT_FREQ_HZ_DEF
) (
    input  logic clk_50MHz,
    input  logic reset,
    output logic clk_100Hz
`ifdef CLK_DIV_TICK_EN
    ,
    output logic tick_100Hz
`endif
);

    localparam int unsigned HALF_CNT = half_cnt(IN_FREQ_HZ, OUT_FREQ_HZ);

    // Reject ratios that cannot give an exact 50% duty output.
    if (OUT_FREQ_HZ == 0) begin : g_bad_out_freq
        $error("clk_divider_100hz: OUT_FREQ_HZ must be non-zero");
    end else if ((IN_FREQ_HZ % (2 * OUT_FREQ_HZ)) != 0) begin : g_bad_ratio
        $error("clk_divider_100hz: IN_FREQ_HZ not divisible by 2*OUT_FREQ_HZ");
    end else if (HALF_CNT < 1) begin : g_bad_half
        $error("clk_divider_100hz: HALF_CNT must be at least 1");
    end

    logic tc_c;

    clk_div_counter #(
        .HALF_CNT (HALF_CNT)
    ) u_counter (
        .clk   (clk_50MHz),
        .reset (reset),
        .tc_c  (tc_c)
    );

    // Output flop toggles once per half-period; reset forces low regardless of phase.
    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            clk_100Hz <= 1'b0;
        end else if (tc_c) begin
            clk_100Hz <= ~clk_100Hz;
        end
    end

`ifdef CLK_DIV_TICK_EN
    // Pulse coincides with the rising output edge: a terminal count while the output is low.
    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            tick_100Hz <= 1'b0;
        end else begin
            tick_100Hz <= tc_c & ~clk_100Hz;
        end
    end
`endif

endmodule

// File: tb/tb_clk_divider_100hz.sv
// Bench for clk_divider_100hz: a small (HALF_CNT=5) and a medium (HALF_CNT=1000) instance,
// each checked against a phase model through an expected-value queue.
module tb_clk_divider_100hz;

    localparam int unsigned HS = 5;      // 1000 Hz / (2*100 Hz)
    localparam int unsigned HM = 1000;   // 200 kHz / (2*100 Hz)

    typedef struct packed {
        logic clk;
        logic tick;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_s = 1'b0;
    logic rst_m = 1'b0;
    logic clk_s;
    logic clk_m;
`ifdef CLK_DIV_TICK_EN
    logic tick_s;
    logic tick_m;
`endif

    int n_run  = 0;
    int n_fail = 0;

    exp_t q_s[$];
    exp_t q_m[$];
    bit   mon_s = 1'b0;
    bit   mon_m = 1'b0;
    int unsigned k_s = 0;
    int unsigned k_m = 0;
    exp_t es;
    exp_t em;

    always #10 clk = ~clk;

    clk_divider_100hz #(
        .IN_FREQ_HZ  (1000),
        .OUT_FREQ_HZ (100)
    ) dut_s (
        .clk_50MHz  (clk),
        .reset      (rst_s),
        .clk_100Hz  (clk_s)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick_100Hz (tick_s)
`endif
    );

    clk_divider_100hz #(
        .IN_FREQ_HZ  (200_000),
        .OUT_FREQ_HZ (100)
    ) dut_m (
        .clk_50MHz  (clk),
        .reset      (rst_m),
        .clk_100Hz  (clk_m)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick_100Hz (tick_m)
`endif
    );

    // Phase model: k = edges sampled with reset high since the last reset edge.
    always @(posedge clk) begin
        if (!rst_s) k_s = 0; else k_s = k_s + 1;
        es.clk  = ((k_s / HS) % 2) == 1;
        es.tick = (k_s % (2 * HS)) == HS;
        if (mon_s) q_s.push_back(es);
    end

    always @(posedge clk) begin
        if (!rst_m) k_m = 0; else k_m = k_m + 1;
        em.clk  = ((k_m / HM) % 2) == 1;
        em.tick = (k_m % (2 * HM)) == HM;
        if (mon_m) q_m.push_back(em);
    end

    task automatic test_reset();
        exp_t e;
        int first_rise = -1;
        q_s.delete();
        mon_s = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rst_s = (c < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (q_s.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL reset_sb_empty: no expected entry at cycle %0d", c);
            end else begin
                e = q_s.pop_front();
                n_run++;
                if (clk_s !== e.clk) begin
                    n_fail++;
                    $display("FAIL reset_sb_clk: got %b expected %b cycle %0d", clk_s, e.clk, c);
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== e.tick) begin
                    n_fail++;
                    $display("FAIL reset_sb_tick: got %b expected %b cycle %0d", tick_s, e.tick, c);
                end
`endif
            end
            if (c < 5) begin
                n_run++;
                if (clk_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_hold: clk_100Hz got %b expected 0 cycle %0d", clk_s, c);
                end
            end else if (clk_s === 1'b1 && first_rise < 0) begin
                first_rise = c - 4;
            end
        end
        n_run++;
        if (first_rise != HS) begin
            n_fail++;
            $display("FAIL first_rise_small: got edge %0d expected edge %0d", first_rise, HS);
        end
        mon_s = 1'b0;
    endtask

    task automatic test_steady();
        exp_t e;
        logic prev = clk_s;
        int last_rise = -1;
        int last_fall = -1;
        int n_rise = 0;
        q_s.delete();
        mon_s = 1'b1;
        for (int c = 0; c < 60; c++) begin
            rst_s = 1'b1;
            @(negedge clk);
            if (q_s.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL steady_sb_empty: no expected entry at cycle %0d", c);
            end else begin
                e = q_s.pop_front();
                n_run++;
                if (clk_s !== e.clk) begin
                    n_fail++;
                    $display("FAIL steady_sb_clk: got %b expected %b cycle %0d", clk_s, e.clk, c);
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== e.tick) begin
                    n_fail++;
                    $display("FAIL steady_sb_tick: got %b expected %b cycle %0d", tick_s, e.tick, c);
                end
`endif
            end
            if (prev === 1'b0 && clk_s === 1'b1) begin
                n_rise++;
                if (last_fall >= 0) begin
                    n_run++;
                    if (c - last_fall != HS) begin
                        n_fail++;
                        $display("FAIL low_len_small: got %0d expected %0d", c - last_fall, HS);
                    end
                end
                if (last_rise >= 0) begin
                    n_run++;
                    if (c - last_rise != 2 * HS) begin
                        n_fail++;
                        $display("FAIL period_small: got %0d expected %0d", c - last_rise, 2 * HS);
                    end
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tick_on_rise: got %b expected 1 cycle %0d", tick_s, c);
                end
`endif
                last_rise = c;
            end else if (prev === 1'b1 && clk_s === 1'b0) begin
                if (last_rise >= 0) begin
                    n_run++;
                    if (c - last_rise != HS) begin
                        n_fail++;
                        $display("FAIL high_len_small: got %0d expected %0d", c - last_rise, HS);
                    end
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_on_fall: got %b expected 0 cycle %0d", tick_s, c);
                end
`endif
                last_fall = c;
            end
            prev = clk_s;
        end
        n_run++;
        if (n_rise != 60 / (2 * HS)) begin
            n_fail++;
            $display("FAIL rise_count_small: got %0d expected %0d", n_rise, 60 / (2 * HS));
        end
        mon_s = 1'b0;
    endtask

    task automatic test_tick_reset();
        exp_t e;
        bit fire = 1'b0;
        bit done = 1'b0;
        q_s.delete();
        mon_s = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!done && (k_s % (2 * HS)) == HS - 1) begin
                rst_s = 1'b0;
                fire  = 1'b1;
            end else begin
                rst_s = 1'b1;
            end
            @(negedge clk);
            if (q_s.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL tickrst_sb_empty: no expected entry at cycle %0d", c);
            end else begin
                e = q_s.pop_front();
                n_run++;
                if (clk_s !== e.clk) begin
                    n_fail++;
                    $display("FAIL tickrst_sb_clk: got %b expected %b cycle %0d", clk_s, e.clk, c);
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== e.tick) begin
                    n_fail++;
                    $display("FAIL tickrst_sb_tick: got %b expected %b cycle %0d", tick_s, e.tick, c);
                end
`endif
            end
            if (fire) begin
                n_run++;
                if (clk_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tickrst_clk: got %b expected 0", clk_s);
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tickrst_tick: got %b expected 0", tick_s);
                end
`endif
                fire = 1'b0;
                done = 1'b1;
            end
        end
        n_run++;
        if (!done) begin
            n_fail++;
            $display("FAIL tickrst_timeout: got no tick slot expected one within 40 cycles");
        end
        mon_s = 1'b0;
    endtask

    task automatic test_random_reset();
        exp_t e;
        q_s.delete();
        mon_s = 1'b1;
        for (int c = 0; c < 300; c++) begin
            rst_s = ($urandom_range(0, 15) != 0);
            @(negedge clk);
            if (q_s.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL rand_sb_empty: no expected entry at cycle %0d", c);
            end else begin
                e = q_s.pop_front();
                n_run++;
                if (clk_s !== e.clk) begin
                    n_fail++;
                    $display("FAIL rand_sb_clk: got %b expected %b cycle %0d", clk_s, e.clk, c);
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_s !== e.tick) begin
                    n_fail++;
                    $display("FAIL rand_sb_tick: got %b expected %b cycle %0d", tick_s, e.tick, c);
                end
`endif
            end
        end
        rst_s = 1'b1;
        mon_s = 1'b0;
    endtask

    task automatic test_medium();
        exp_t e;
        logic prev = 1'b0;
        int first_rise = -1;
        int last_rise = -1;
        int last_fall = -1;
        int n_len = 0;
        q_m.delete();
        mon_m = 1'b1;
        for (int c = 0; c < 3 + 4 * HM + 10; c++) begin
            rst_m = (c < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (q_m.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL med_sb_empty: no expected entry at cycle %0d", c);
            end else begin
                e = q_m.pop_front();
                n_run++;
                if (clk_m !== e.clk) begin
                    n_fail++;
                    $display("FAIL med_sb_clk: got %b expected %b cycle %0d", clk_m, e.clk, c);
                end
`ifdef CLK_DIV_TICK_EN
                n_run++;
                if (tick_m !== e.tick) begin
                    n_fail++;
                    $display("FAIL med_sb_tick: got %b expected %b cycle %0d", tick_m, e.tick, c);
                end
`endif
            end
            if (c < 3) begin
                n_run++;
                if (clk_m !== 1'b0) begin
                    n_fail++;
                    $display("FAIL med_reset_hold: got %b expected 0 cycle %0d", clk_m, c);
                end
            end
            if (prev === 1'b0 && clk_m === 1'b1) begin
                if (first_rise < 0) first_rise = c - 2;
                if (last_fall >= 0) begin
                    n_run++; n_len++;
                    if (c - last_fall != HM) begin
                        n_fail++;
                        $display("FAIL low_len_med: got %0d expected %0d", c - last_fall, HM);
                    end
                end
                if (last_rise >= 0) begin
                    n_run++;
                    if (c - last_rise != 2 * HM) begin
                        n_fail++;
                        $display("FAIL period_med: got %0d expected %0d", c - last_rise, 2 * HM);
                    end
                end
                last_rise = c;
            end else if (prev === 1'b1 && clk_m === 1'b0) begin
                if (last_rise >= 0) begin
                    n_run++; n_len++;
                    if (c - last_rise != HM) begin
                        n_fail++;
                        $display("FAIL high_len_med: got %0d expected %0d", c - last_rise, HM);
                    end
                end
                last_fall = c;
            end
            prev = clk_m;
        end
        n_run++;
        if (first_rise != HM) begin
            n_fail++;
            $display("FAIL first_rise_med: got edge %0d expected edge %0d", first_rise, HM);
        end
        n_run++;
        if (n_len < 3) begin
            n_fail++;
            $display("FAIL med_len_count: got %0d expected at least 3", n_len);
        end
        mon_m = 1'b0;
    endtask

    task automatic test_mid_high_reset();
        exp_t e;
        int ph = 0;
        int hi = 0;
        int edges = 0;
        q_m.delete();
        mon_m = 1'b1;
        for (int c = 0; c < 5 * HM && ph != 3; c++) begin
            rst_m = (ph == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (q_m.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL midrst_sb_empty: no expected entry at cycle %0d", c);
            end else begin
                e = q_m.pop_front();
                n_run++;
                if (clk_m !== e.clk) begin
                    n_fail++;
                    $display("FAIL midrst_sb_clk: got %b expected %b cycle %0d", clk_m, e.clk, c);
                end
            end
            if (ph == 0) begin
                if (clk_m === 1'b1) hi++;
                if (hi == 400) ph = 1;
            end else if (ph == 1) begin
                n_run++;
                if (clk_m !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_force_low: got %b expected 0", clk_m);
                end
                ph = 2;
            end else begin
                edges++;
                if (clk_m === 1'b1) begin
                    n_run++;
                    if (edges != HM) begin
                        n_fail++;
                        $display("FAIL midrst_next_rise: got edge %0d expected edge %0d", edges, HM);
                    end
                    ph = 3;
                end
            end
        end
        n_run++;
        if (ph != 3) begin
            n_fail++;
            $display("FAIL midrst_timeout: got phase %0d expected 3", ph);
        end
        mon_m = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_steady();
        test_tick_reset();
        test_random_reset();
        test_medium();
        test_mid_high_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
